// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_param
//  Description : Parameterised serial sequence detector. Valid input bits are
//                shifted into a history register; once PAT_W bits have been
//                collected since the last restart, the newest PAT_W bits are
//                compared against a loadable pattern. A match produces a
//                registered one-cycle pulse and bumps a saturating counter.
//                Overlapping or non-overlapping matching is selected per
//                match via the overlap input.
//  Ports       : clk            - rising-edge clock
//                rst            - asynchronous active-low reset
//                din            - serial data bit
//                din_valid      - qualifies din
//                pattern        - target sequence, MSB is first bit received
//                load           - latch pattern, clear history
//                overlap        - 1 = overlapping matches allowed
//                count_clr      - synchronous clear of match_count
//                sequence_found - one-cycle match pulse (registered)
//                match_count    - saturating match counter (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             load,
    input  logic             overlap,
    input  logic             count_clr,
    output logic             sequence_found,
    output logic [CNT_W-1:0] match_count
);

    // Fill counter only needs to reach PAT_W-1.
    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0] pat_q,   pat_d;
    logic [PAT_W-2:0] hist_q,  hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PAT_W-1:0] w_window;
    logic             w_match;

    // Newest PAT_W bits including the bit being sampled on this edge.
    assign w_window = {hist_q, din};

    // A load cycle discards the incoming bit, so it can never match.
    assign w_match  = din_valid && !load && (fill_q == FILL_MAX) && (w_window == pat_q);

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        found_d = w_match;
        count_d = count_q;

        if (load) begin
            pat_d  = pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (din_valid) begin
            hist_d = w_window[PAT_W-2:0];
            // Non-overlapping mode restarts collection after a match so the
            // next match needs a full fresh pattern's worth of bits.
            if (w_match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        // Clear takes priority over a coincident match.
        if (count_clr) begin
            count_d = '0;
        end else if (w_match && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= '1;
            hist_q  <= '0;
            fill_q  <= '0;
            found_q <= 1'b0;
            count_q <= '0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            found_q <= found_d;
            count_q <= count_d;
        end
    end

    assign sequence_found = found_q;
    assign match_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_det_param
//  Description : Self-checking bench for seq_det_param (PAT_W=4, CNT_W=2).
//                Directed table vectors, hand-written reset/saturation
//                sequences, then randomized traffic against a queue-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             din;
    logic             din_valid;
    logic [PAT_W-1:0] pattern;
    logic             load;
    logic             overlap;
    logic             count_clr;
    logic             sequence_found;
    logic [CNT_W-1:0] match_count;

    int checks;
    int errors;

    // Reference model: bits collected since the last restart, current
    // pattern, and expected outputs.
    int               m_bits[$];
    int               m_pat;
    int               m_cnt;
    int               m_found;

    seq_det_param #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .din_valid     (din_valid),
        .pattern       (pattern),
        .load          (load),
        .overlap       (overlap),
        .count_clr     (count_clr),
        .sequence_found(sequence_found),
        .match_count   (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       d;
        logic       l;
        logic       o;
        logic       c;
        logic       ef;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int act_f, input int exp_f,
                         input int act_c, input int exp_c);
        checks++;
        if (act_f != exp_f || act_c != exp_c) begin
            errors++;
            $display("FAIL %s: found=%0d count=%0d, expected found=%0d count=%0d",
                     nm, act_f, act_c, exp_f, exp_c);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat   = (1 << PAT_W) - 1;
        m_cnt   = 0;
        m_found = 0;
    endtask

    // Model of one clock edge, computed from the rules directly: a match is
    // the last PAT_W valid bits since restart equalling the pattern.
    task automatic model_edge(input int v, input int d, input int l, input int o,
                              input int c, input int p);
        int win;
        int n;
        int match;
        match = 0;
        if (l != 0) begin
            m_pat = p;
            m_bits.delete();
        end else if (v != 0) begin
            m_bits.push_back(d);
            n = m_bits.size();
            if (n >= PAT_W) begin
                win = 0;
                for (int k = n - PAT_W; k < n; k++) win = win * 2 + m_bits[k];
                if (win == m_pat) begin
                    match = 1;
                    if (o == 0) m_bits.delete();
                end
            end
            while (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        end
        if (c != 0) m_cnt = 0;
        else if (match != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_found = match;
    endtask

    task automatic drive(input logic v, input logic d, input logic l, input logic o,
                         input logic c, input logic [PAT_W-1:0] p);
        din_valid = v;
        din       = d;
        load      = l;
        overlap   = o;
        count_clr = c;
        pattern   = p;
        @(posedge clk);
        model_edge(int'(v), int'(d), int'(l), int'(o), int'(c), int'(p));
        #1;
    endtask

    // Helpers to build the directed table.
    function automatic void add(input logic v, input logic d, input logic l, input logic o,
                                input logic c, input logic ef, input logic [1:0] ec);
        vec_t e;
        e.v = v; e.d = d; e.l = l; e.o = o; e.c = c; e.ef = ef; e.ec = ec;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [3:0] bits4;
        logic [3:0] seq7;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        pattern   = '0;
        load      = 1'b0;
        overlap   = 1'b0;
        count_clr = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", int'(sequence_found), 0, int'(match_count), 0);
        #2 rst = 1'b1;

        // ---------------- directed table ----------------
        // Overlap: 1,0,1,1,0,1,1 -> pulses after bits 4 and 7
        add(0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 1, 1);
        add(1, 0, 0, 1, 0, 0, 1);
        add(1, 1, 0, 1, 0, 0, 1);
        add(1, 1, 0, 1, 0, 1, 2);
        // Non-overlap: same stream -> one pulse after bit 4
        add(0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1);
        // Valid gaps between bits 2 and 3
        add(0, 0, 1, 1, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 1);
        // Load mid-stream: 1,0,1, load (with discarded 1), 0,1,1, then 1,0,1,1
        add(0, 0, 1, 1, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o, tbl[i].c, 4'b1011);
            check($sformatf("tbl[%0d]", i), int'(sequence_found), int'(tbl[i].ef),
                  int'(match_count), int'(tbl[i].ec));
        end

        // ---------------- saturation and clear ----------------
        drive(0, 0, 1, 0, 1, 4'b1011);
        bits4 = 4'b1011;
        for (int m = 1; m <= 6; m++) begin
            for (int b = 3; b >= 0; b--) begin
                drive(1, bits4[b], 0, 0, (m == 6 && b == 0) ? 1'b1 : 1'b0, 4'b1011);
            end
            check($sformatf("sat_match%0d", m), int'(sequence_found), 1,
                  int'(match_count), (m == 6) ? 0 : ((m > 3) ? 3 : m));
        end

        // ---------------- async reset ----------------
        // Reset while a pulse is showing must clear it without a clock edge.
        drive(0, 0, 1, 1, 1, 4'b1011);
        seq7 = 4'b1011;
        for (int b = 3; b >= 0; b--) drive(1, seq7[b], 0, 1, 0, 4'b1011);
        check("pre_rst_pulse", int'(sequence_found), 1, int'(match_count), 1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rst_cancels_pulse", int'(sequence_found), 0, int'(match_count), 0);
        #1 rst = 1'b1;

        // Partial match 1,0,1 then reset between edges, then a 1 -> no pulse.
        drive(0, 0, 1, 1, 0, 4'b1011);
        drive(1, 1, 0, 1, 0, 4'b1011);
        drive(1, 0, 0, 1, 0, 4'b1011);
        drive(1, 1, 0, 1, 0, 4'b1011);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rst_midstream", int'(sequence_found), 0, int'(match_count), 0);
        #1 rst = 1'b1;
        drive(1, 1, 0, 1, 0, 4'b1011);
        check("post_rst_bit", int'(sequence_found), 0, int'(match_count), 0);
        // Pattern register resets to all-ones: three more 1s complete a match.
        drive(1, 1, 0, 1, 0, 4'b0000);
        drive(1, 1, 0, 1, 0, 4'b0000);
        check("post_rst_3ones", int'(sequence_found), 0, int'(match_count), 0);
        drive(1, 1, 0, 1, 0, 4'b0000);
        check("rst_pattern_ones", int'(sequence_found), 1, int'(match_count), 1);

        // ---------------- randomized vs. model ----------------
        drive(0, 0, 1, 1, 1, 4'b1011);
        for (int i = 0; i < 600; i++) begin
            logic v, d, l, o, c;
            logic [PAT_W-1:0] p;
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            l = ($urandom_range(0, 39) == 0);
            o = 1'($urandom);
            c = ($urandom_range(0, 11) == 0);
            // Keep pattern space small so matches are frequent.
            p = ($urandom_range(0, 1) != 0) ? 4'b1011 : PAT_W'($urandom);
            drive(v, d, l, o, c, p);
            check($sformatf("rand[%0d]", i), int'(sequence_found), m_found,
                  int'(match_count), m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
